// File: rtl/rv_exec_pkg.sv
// Shared encodings and types for the RV32 execute stage and its mul/div engine.
package rv_exec_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} exec_state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_BRANCH, CLS_JUMP, CLS_UPPER, CLS_MULDIV, CLS_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/rv_exec_unit_muldiv.sv
// Iterative RV32M engine: shift-add multiply / restoring divide on magnitudes,
// one bit per cycle, signs restored from the registered result.
module rv_muldiv_iter import rv_exec_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [2:0]            i_func3,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_hi, r_lo, r_b;
    logic [2:0]    r_f3;
    logic          r_neg_q, r_neg_r, r_bzero;

    logic          w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_div;
    logic [W-1:0]  w_a_abs, w_b_abs, s_hi, s_lo, s_b, n_hi, n_lo;
    logic [W:0]    w_sum, w_rs, w_diff;

    assign w_a_sgn = (i_func3 == F3_MULH) || (i_func3 == F3_MULHSU) ||
                     (i_func3 == F3_DIV)  || (i_func3 == F3_REM);
    assign w_b_sgn = (i_func3 == F3_MULH) || (i_func3 == F3_DIV) || (i_func3 == F3_REM);
    assign w_a_neg = w_a_sgn & i_a[W-1];
    assign w_b_neg = w_b_sgn & i_b[W-1];
    assign w_a_abs = w_a_neg ? -i_a : i_a;
    assign w_b_abs = w_b_neg ? -i_b : i_b;

    // The start cycle already performs the first step so the total latency is W edges.
    assign s_hi  = i_start ? '0 : r_hi;
    assign s_lo  = i_start ? w_a_abs : r_lo;
    assign s_b   = i_start ? w_b_abs : r_b;
    assign w_div = i_start ? i_func3[2] : r_f3[2];

    assign w_sum  = {1'b0, s_hi} + (s_lo[0] ? {1'b0, s_b} : '0);
    assign w_rs   = {s_hi, s_lo[W-1]};
    assign w_diff = w_rs - {1'b0, s_b};

    always_comb begin
        n_hi = w_sum[W:1];
        n_lo = {w_sum[0], s_lo[W-1:1]};
        if (w_div) begin
            if (!w_diff[W]) begin
                n_hi = w_diff[W-1:0];
                n_lo = {s_lo[W-2:0], 1'b1};
            end else begin
                n_hi = w_rs[W-1:0];
                n_lo = {s_lo[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= CW'(1);
            r_hi    <= n_hi;
            r_lo    <= n_lo;
            r_b     <= w_b_abs;
            r_f3    <= i_func3;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_bzero <= (i_b == '0);
        end else if (r_busy) begin
            if (r_cnt == CW'(W)) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                r_hi  <= n_hi;
                r_lo  <= n_lo;
            end
        end
    end

    assign o_done = r_busy && (r_cnt == CW'(W));

    logic [2*W-1:0] w_prod, w_prod_s;
    logic [W-1:0]   w_quo, w_rem;

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    // Divide by zero yields all ones regardless of the dividend sign.
    assign w_quo    = r_bzero ? '1 : (r_neg_q ? -r_lo : r_lo);
    assign w_rem    = r_neg_r ? -r_hi : r_hi;

    always_comb begin
        o_result = w_prod_s[W-1:0];
        case (r_f3)
            F3_MULH, F3_MULHSU, F3_MULHU: o_result = w_prod_s[2*W-1:W];
            F3_DIV, F3_DIVU:              o_result = w_quo;
            F3_REM, F3_REMU:              o_result = w_rem;
            default:                      o_result = w_prod_s[W-1:0];
        endcase
    end

endmodule

// File: rtl/rv_exec_unit.sv
// RV32 execute stage: ALU, branch/jump targets, LUI/AUIPC, one instruction at a time.
// Define RV_M_EXT_EN to add RV32M via the iterative rv_muldiv_iter engine.
module rv_exec_unit import rv_exec_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [6:0]            i_opcode,
    input  logic [2:0]            i_func3,
    input  logic [6:0]            i_func7,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rf_we,
    output logic [DATA_WIDTH-1:0] o_pc_next,
    output logic                  o_illegal
);
    localparam int W = DATA_WIDTH;

    exec_state_t  r_state;
    logic [W-1:0] r_rd_data, r_pc_next;
    logic         r_rf_we, r_illegal;

    op_class_t    w_cls;
    logic         w_alt, w_taken, w_we;
    logic [W-1:0] w_b, w_alu, w_res, w_pcn, w_pc4, w_jt;
    logic [SHAMT_W-1:0] w_shamt;

    assign w_pc4   = i_pc + W'(4);
    assign w_b     = (i_opcode == OPC_OP) ? i_rs2_data : i_imm;
    assign w_shamt = w_b[SHAMT_W-1:0];
    assign w_jt    = i_rs1_data + i_imm;

    always_comb begin
        w_cls = CLS_ILLEGAL;
        w_alt = 1'b0;
        case (i_opcode)
            OPC_OP: begin
                if (i_func7 == F7_BASE) begin
                    w_cls = CLS_ALU;
                end else if (i_func7 == F7_ALT && (i_func3 == F3_ADD || i_func3 == F3_SR)) begin
                    w_cls = CLS_ALU;
                    w_alt = 1'b1;
                end
`ifdef RV_M_EXT_EN
                else if (i_func7 == F7_MULDIV) begin
                    w_cls = CLS_MULDIV;
                end
`endif
            end
            OPC_OP_IMM: begin
                // Only the shift forms constrain func7; there is no SUBI.
                if (i_func3 == F3_SLL) begin
                    if (i_func7 == F7_BASE) w_cls = CLS_ALU;
                end else if (i_func3 == F3_SR) begin
                    if (i_func7 == F7_BASE) begin
                        w_cls = CLS_ALU;
                    end else if (i_func7 == F7_ALT) begin
                        w_cls = CLS_ALU;
                        w_alt = 1'b1;
                    end
                end else begin
                    w_cls = CLS_ALU;
                end
            end
            OPC_BRANCH:         if (i_func3 != 3'b010 && i_func3 != 3'b011) w_cls = CLS_BRANCH;
            OPC_JAL:            w_cls = CLS_JUMP;
            OPC_JALR:           if (i_func3 == 3'b000) w_cls = CLS_JUMP;
            OPC_LUI, OPC_AUIPC: w_cls = CLS_UPPER;
            default:            w_cls = CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (i_func3)
            F3_ADD:  w_alu = w_alt ? (i_rs1_data - w_b) : (i_rs1_data + w_b);
            F3_SLL:  w_alu = i_rs1_data << w_shamt;
            F3_SLT:  w_alu = W'($signed(i_rs1_data) < $signed(w_b));
            F3_SLTU: w_alu = W'(i_rs1_data < w_b);
            F3_XOR:  w_alu = i_rs1_data ^ w_b;
            F3_SR:   w_alu = w_alt ? $unsigned($signed(i_rs1_data) >>> w_shamt)
                                   : (i_rs1_data >> w_shamt);
            F3_OR:   w_alu = i_rs1_data | w_b;
            F3_AND:  w_alu = i_rs1_data & w_b;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (i_func3)
            F3_BEQ:  w_taken = (i_rs1_data == i_rs2_data);
            F3_BNE:  w_taken = (i_rs1_data != i_rs2_data);
            F3_BLT:  w_taken = ($signed(i_rs1_data) < $signed(i_rs2_data));
            F3_BGE:  w_taken = !($signed(i_rs1_data) < $signed(i_rs2_data));
            F3_BLTU: w_taken = (i_rs1_data < i_rs2_data);
            F3_BGEU: w_taken = !(i_rs1_data < i_rs2_data);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_res = '0;
        w_we  = 1'b0;
        w_pcn = w_pc4;
        case (w_cls)
            CLS_ALU: begin
                w_res = w_alu;
                w_we  = 1'b1;
            end
            CLS_BRANCH: if (w_taken) w_pcn = i_pc + i_imm;
            CLS_JUMP: begin
                w_res = w_pc4;
                w_we  = 1'b1;
                w_pcn = (i_opcode == OPC_JALR) ? {w_jt[W-1:1], 1'b0} : (i_pc + i_imm);
            end
            CLS_UPPER: begin
                w_res = ((i_opcode == OPC_LUI) ? '0 : i_pc) + (i_imm << 12);
                w_we  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RV_M_EXT_EN
    logic         w_md_start, w_md_done;
    logic [W-1:0] w_md_res;

    assign w_md_start = !i_rst && (r_state == IDLE) && i_in_valid && (w_cls == CLS_MULDIV);

    rv_muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (w_md_start),
        .i_func3  (i_func3),
        .i_a      (i_rs1_data),
        .i_b      (i_rs2_data),
        .o_done   (w_md_done),
        .o_result (w_md_res)
    );
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_rd_data <= '0;
            r_rf_we   <= 1'b0;
            r_pc_next <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_pc_next <= w_pcn;
`ifdef RV_M_EXT_EN
                    if (w_cls == CLS_MULDIV) begin
                        r_state <= BUSY;
                    end else
`endif
                    begin
                        r_rd_data <= w_res;
                        r_rf_we   <= w_we;
                        r_illegal <= (w_cls == CLS_ILLEGAL);
                        r_state   <= DONE;
                    end
                end
`ifdef RV_M_EXT_EN
                BUSY: if (w_md_done) begin
                    r_rd_data <= w_md_res;
                    r_rf_we   <= 1'b1;
                    r_illegal <= 1'b0;
                    r_state   <= DONE;
                end
`endif
                DONE:    if (i_out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_in_ready  = !i_rst && (r_state == IDLE);
    assign o_out_valid = (r_state == DONE);
    assign o_rd_data   = r_rd_data;
    assign o_rf_we     = r_rf_we;
    assign o_pc_next   = r_pc_next;
    assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_rv_exec_unit.sv
// Directed, table-driven bench for rv_exec_unit plus hand sequences for
// backpressure, reset abort and (when RV_M_EXT_EN is defined) the mul/div engine.
module tb_rv_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [31:0] rs1, rs2, imm, pc, rd_data, pc_next;
    logic        rf_we, illegal;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_exec_unit dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_opcode(opcode), .i_func3(func3), .i_func7(func7),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_imm(imm), .i_pc(pc),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_rd_data(rd_data), .o_rf_we(rf_we), .o_pc_next(pc_next), .o_illegal(illegal)
    );

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b, im, p;
        logic [31:0] e_rd, e_pcn;
        logic        e_we, e_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p, input logic [31:0] e_rd,
                       input logic e_we, input logic [31:0] e_pcn, input logic e_ill);
        vec_t v;
        v.name = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.im = im; v.p = p;
        v.e_rd = e_rd; v.e_we = e_we; v.e_pcn = e_pcn; v.e_ill = e_ill;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] p);
        opcode = op; func3 = f3; func7 = f7; rs1 = a; rs2 = b; imm = im; pc = p;
    endtask

    // Present one single-cycle instruction, check the result one cycle later, retire it.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        drive(v.op, v.f3, v.f7, v.a, v.b, v.im, v.p);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({v.name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({v.name, " rd_data"}, rd_data, v.e_rd);
        chk({v.name, " rf_we"}, 32'(rf_we), 32'(v.e_we));
        chk({v.name, " pc_next"}, pc_next, v.e_pcn);
        chk({v.name, " illegal"}, 32'(illegal), 32'(v.e_ill));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({v.name, " retire"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

`ifdef RV_M_EXT_EN
    task automatic run_m(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e_rd, input int hold);
        int lat;
        @(negedge clk);
        drive(7'b0110011, f3, 7'b0000001, a, b, 32'd0, 32'h400);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'd32);
        chk({nm, " rd_data"}, rd_data, e_rd);
        chk({nm, " rf_we"}, 32'(rf_we), 32'd1);
        chk({nm, " pc_next"}, pc_next, 32'h404);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, " held"}, {out_valid, in_ready, rd_data[29:0]}, {1'b1, 1'b0, e_rd[29:0]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " retire"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        add("ADD",   7'b0110011, 3'b000, 7'h00, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h100, 32'h8000_0000, 1, 32'h104, 0);
        add("SUB",   7'b0110011, 3'b000, 7'h20, 32'd5, 32'd7, 32'd0, 32'h100, 32'hFFFF_FFFE, 1, 32'h104, 0);
        add("SRA",   7'b0110011, 3'b101, 7'h20, 32'h8000_0000, 32'h24, 32'd0, 32'h100, 32'hF800_0000, 1, 32'h104, 0);
        add("SRL",   7'b0110011, 3'b101, 7'h00, 32'h8000_0000, 32'h24, 32'd0, 32'h100, 32'h0800_0000, 1, 32'h104, 0);
        add("SLT",   7'b0110011, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h100, 32'd1, 1, 32'h104, 0);
        add("SLTU",  7'b0110011, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h100, 32'd0, 1, 32'h104, 0);
        add("AND",   7'b0110011, 3'b111, 7'h00, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'h100, 32'h00F0_1200, 1, 32'h104, 0);
        add("XORI",  7'b0010011, 3'b100, 7'h7F, 32'h0000_F0F0, 32'd0, 32'hFFFF_FFFF, 32'h100, 32'hFFFF_0F0F, 1, 32'h104, 0);
        add("SLLI",  7'b0010011, 3'b001, 7'h00, 32'd1, 32'd0, 32'h1F, 32'h100, 32'h8000_0000, 1, 32'h104, 0);
        add("BNE",   7'b1100011, 3'b001, 7'h00, 32'd3, 32'd4, 32'h20, 32'h100, 32'd0, 0, 32'h120, 0);
        add("BEQ",   7'b1100011, 3'b000, 7'h00, 32'd3, 32'd4, 32'h20, 32'h100, 32'd0, 0, 32'h104, 0);
        add("BLT",   7'b1100011, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h100, 32'd0, 0, 32'h0F0, 0);
        add("BLTU",  7'b1100011, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h100, 32'd0, 0, 32'h104, 0);
        add("BGEU",  7'b1100011, 3'b111, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h100, 32'd0, 0, 32'h140, 0);
        add("JAL",   7'b1101111, 3'b000, 7'h00, 32'd0, 32'd0, 32'h40, 32'h100, 32'h104, 1, 32'h140, 0);
        add("JALR",  7'b1100111, 3'b000, 7'h00, 32'h201, 32'd0, 32'd0, 32'h300, 32'h304, 1, 32'h200, 0);
        add("LUI",   7'b0110111, 3'b000, 7'h00, 32'd0, 32'd0, 32'h12345, 32'h100, 32'h1234_5000, 1, 32'h104, 0);
        add("AUIPC", 7'b0010111, 3'b000, 7'h00, 32'd0, 32'd0, 32'd1, 32'h100, 32'h0000_1100, 1, 32'h104, 0);
        add("ILLOP", 7'b1111111, 3'b000, 7'h00, 32'd9, 32'd9, 32'd9, 32'h100, 32'd0, 0, 32'h104, 1);
        add("ILLSLL",7'b0110011, 3'b001, 7'h20, 32'd9, 32'd1, 32'd0, 32'h100, 32'd0, 0, 32'h104, 1);
`ifndef RV_M_EXT_EN
        add("MULILL",7'b0110011, 3'b000, 7'h01, 32'd3, 32'd5, 32'd0, 32'h100, 32'd0, 0, 32'h104, 1);
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst outputs", {out_valid, rf_we, illegal, 29'd0}, 32'd0);
        chk("rst rd_data", rd_data, 32'd0);
        chk("rst pc_next", pc_next, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", 32'(in_ready), 32'd1);
        chk("post-rst out_valid", 32'(out_valid), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result held, competing instruction not accepted meanwhile
        @(negedge clk);
        drive(7'b0110011, 3'b000, 7'h00, 32'd10, 32'd20, 32'd0, 32'h500);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(7'b0110011, 3'b110, 7'h00, 32'hF0, 32'h0F, 32'd0, 32'h600);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp held", {out_valid, in_ready, rd_data[29:0]}, {1'b1, 1'b0, 30'd30});
            chk("bp pc_next", pc_next, 32'h504);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release", {30'd0, out_valid, in_ready}, 32'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp second rd", rd_data, 32'hFF);
        chk("bp second pc", pc_next, 32'h604);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset while in DONE aborts the result
        @(negedge clk);
        drive(7'b0110011, 3'b000, 7'h00, 32'd1, 32'd2, 32'd0, 32'h700);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort done", {30'd0, out_valid, in_ready}, 32'b01);
        chk("abort rd", rd_data, 32'd0);

`ifdef RV_M_EXT_EN
        run_m("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        run_m("MUL",   3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 0);
        run_m("MULH",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0);
        run_m("DIV0",  3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF, 0);
        run_m("REM0",  3'b110, 32'd7, 32'd0, 32'd7, 0);
        run_m("DIVOV", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_m("REMOV", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run_m("DIVNEG",3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_m("REMNEG",3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_m("DIVU",  3'b101, 32'd100, 32'd7, 32'd14, 0);

        // Reset mid-BUSY: nothing is ever presented for the aborted op
        @(negedge clk);
        drive(7'b0110011, 3'b100, 7'h01, 32'd100, 32'd3, 32'd0, 32'h800);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("busy abort in_ready", 32'(in_ready), 32'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("busy abort no valid", 32'(seen), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rv_exec_unit.md
# rv_exec_unit

Multi-cycle RV32 execute stage with valid/ready handshakes on input and output. It computes ALU results, branch and jump targets, and LUI/AUIPC values for one instruction at a time. Results are registered. Loads and stores are out of scope and handled by the LSU. The RV32M multiply/divide extension is optional and, when compiled in, runs on an iterative engine.

## Interface
- DATA_WIDTH, 32, operand/result/PC width; must be a power of two, ≥8
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount bits taken from rs2/imm
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  instruction fields valid
- in_ready  out  1  unit can accept an instruction
- opcode  in  7  RV opcode
- func3  in  3  RV func3
- func7  in  7  RV func7
- rs1_data, rs2_data  in  DATA_WIDTH  register operands
- imm  in  DATA_WIDTH  decoded immediate (already sign-extended; LUI/AUIPC imm is unshifted upper field)
- pc  in  DATA_WIDTH  address of the instruction
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- rd_data  out  DATA_WIDTH  writeback value
- rf_we  out  1  writeback enable
- pc_next  out  DATA_WIDTH  next fetch address
- illegal  out  1  unsupported opcode/func combination

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, the unit captures the operands.
    - Single-cycle op: result is computed and registered, then → DONE.
    - M op: muldiv engine starts, then → BUSY.
  - BUSY: the engine iterates. On the engine's done pulse, the result is registered, then → DONE.
  - DONE: out_valid=1. Outputs are held stable until out_ready, then → IDLE.
- in_ready=0 in BUSY and DONE. There is no overlap between instructions.
- R/I ALU ops:
  - ADD, SUB, XOR, OR, AND.
  - SLL/SRL/SRA use the low SHAMT_W bits only. SRA is a true arithmetic shift.
  - SLT is signed. SLTU is unsigned.
  - SUB exists only for the R form.
- Branches: rf_we=0.
  - BEQ is equal. BNE is not-equal.
  - BLT/BGE are signed. BLTU/BGEU are unsigned.
  - Taken branch: pc_next=pc+imm. Not taken: pc+4.
- JAL: rd_data=pc+4, pc_next=pc+imm.
- JALR: rd_data=pc+4, pc_next=(rs1+imm) with bit 0 cleared.
- LUI: rd_data=imm<<12. AUIPC: rd_data=pc+(imm<<12).
- Every non-branch, non-jump op sets pc_next=pc+4. rf_we=1 for ALU/LUI/AUIPC/JAL/JALR/M ops.
- Illegal combination: rd_data=0, rf_we=0, pc_next=pc+4, illegal=1, single-cycle latency.
- All arithmetic is modulo 2^DATA_WIDTH.
- MULH/MULHSU/MULHU return the upper half of the 2·DATA_WIDTH-bit product.
- Divide by zero: DIV/DIVU return all ones; REM/REMU return rs1.
- Signed overflow (most-negative ÷ −1): DIV returns the dividend, REM returns 0.

## Timing
- Reset, and the cycle after rst deasserts: out_valid=0, rd_data=0, rf_we=0, pc_next=0, illegal=0, state=IDLE.
  - in_ready=0 while rst is high and 1 on the first cycle after release.
- Single-cycle op accepted at edge N: out_valid=1 from cycle N+1.
- M op accepted at edge N: out_valid=1 from cycle N+1+DATA_WIDTH. Latency is fixed and independent of operand values, including ÷0.
- Backpressure: the result is held for any number of cycles while out_ready=0. A new in_valid during that time is not accepted.
- out_valid && out_ready at edge M: in_ready=1 at cycle M+1. There is no same-cycle bypass.
- rst during BUSY or DONE aborts the instruction. No result is ever presented for it.

## Configuration
- RV_M_EXT_EN defined: opcode 0110011 with func7=0000001 executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU via rv_muldiv_iter.
- RV_M_EXT_EN undefined:
  - Those encodings are illegal (illegal=1, single-cycle).
  - The BUSY state and rv_muldiv_iter are not instantiated.

## Structure
- Package rv_exec_pkg holds:
  - opcode localparams (OP, OP_IMM, BRANCH, LUI, AUIPC, JAL, JALR);
  - func3/func7 encodings;
  - typedef enum exec_state_t {IDLE, BUSY, DONE};
  - typedef enum op_class_t {ALU, BRANCH, JUMP, UPPER, MULDIV, ILLEGAL}.
- Sub-module rv_muldiv_iter:
  - start/done interface, one bit per cycle;
  - shift-add multiplier and restoring divider sharing one DATA_WIDTH counter;
  - sign fix-up applied at the end.

## Test plan
- ADD rs1=0x7FFF_FFFF, rs2=1 → rd_data=0x8000_0000, rf_we=1, out_valid one cycle after accept.
- SRA rs1=0x8000_0000, rs2=0x24 (shamt 4) → 0xF800_0000. SLT with rs1=0xFFFF_FFFF, rs2=1 → 1; SLTU with the same operands → 0.
- BNE pc=0x100, rs1=3, rs2=4, imm=0x20 → pc_next=0x120, rf_we=0. JALR rs1=0x201, imm=0 → pc_next=0x200, rd_data=pc+4.
- RV_M_EXT_EN, MULHU 0xFFFF_FFFF×0xFFFF_FFFF with out_ready held 0 for 5 cycles:
  - rd_data=0xFFFF_FFFE;
  - out_valid at accept+33;
  - result stable until out_ready.
- RV_M_EXT_EN:
  - DIV 7÷0 → 0xFFFF_FFFF; REM 7%0 → 7;
  - DIV 0x8000_0000÷0xFFFF_FFFF → 0x8000_0000; REM of the same → 0;
  - rst pulsed mid-BUSY → no out_valid, in_ready=1 after release.
- Without RV_M_EXT_EN, MUL encoding → illegal=1, rf_we=0, rd_data=0, pc_next=pc+4, single-cycle.
